// File: rtl/uart_tx_dev_pkg.sv
// Shared definitions for the UART transmitter: register offsets, STATUS bit
// positions and the frame FSM encoding.
package uart_tx_dev_pkg;

    localparam int XLEN = 32;

    localparam logic [1:0] UART_TXDATA  = 2'd0;
    localparam logic [1:0] UART_STATUS  = 2'd1;
    localparam logic [1:0] UART_BAUDDIV = 2'd2;
    localparam logic [1:0] UART_CTRL    = 2'd3;

    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;
    localparam int STAT_OVF   = 3;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } tx_state_e;

    // A zero divider would stall the bit timer, so it is stored as 1.
    function automatic logic [15:0] div_sanitize(input logic [15:0] v);
        return (v == 16'd0) ? 16'd1 : v;
    endfunction

endpackage

// File: rtl/uart_tx_dev_sync_fifo.sv
// Show-ahead synchronous FIFO; head is visible combinationally on rdata_o.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign rdata_o = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the slot in the same cycle, so a full FIFO can still accept.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    assign rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/uart_tx_dev.sv
// Memory-mapped 8N1 UART transmitter with TX FIFO and TX-empty level interrupt.
module uart_tx_dev
    import uart_tx_dev_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic            we_i,
    input  logic [XLEN-1:0] addr_i,
    input  logic [XLEN-1:0] wdata_i,
    output logic [XLEN-1:0] rdata_o,
    output logic            tx_o,
    output logic            irq_o
);
    // state   | meaning
    // S_IDLE  | line high, waiting for a FIFO byte
    // S_START | start bit (0)
    // S_DATA  | 8 data bits, LSB first
    // S_STOP  | stop bit (1); chains straight into the next frame if data waits
    tx_state_e   state_q, state_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] cnt_q, cnt_d;
    logic        tx_q, tx_d;

    logic [15:0]     div_q;
    logic            irq_en_q, ovf_q, irq_q;
    logic [XLEN-1:0] rdata_q, rd_val;

    logic       fifo_full, fifo_empty, fifo_pop, busy, tc;
    logic       wr, rd, push;
    logic [1:0] sel;
    logic [7:0] fifo_head;
    logic       unused_bits;

    assign unused_bits = ^{addr_i[XLEN-1:4], addr_i[1:0], wdata_i[XLEN-1:16]};

    assign sel  = addr_i[3:2];
    assign wr   = req_i & we_i;
    assign rd   = req_i & ~we_i;
    assign push = wr && (sel == UART_TXDATA);
    assign busy = (state_q != S_IDLE);
    assign tc   = (cnt_q == 16'd0);

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (fifo_pop),
        .wdata_i (wdata_i[7:0]),
        .rdata_o (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        idx_d    = idx_q;
        cnt_d    = tc ? 16'd0 : cnt_q - 16'd1;
        tx_d     = tx_q;
        fifo_pop = 1'b0;
        case (state_q)
            S_IDLE: begin
                tx_d = 1'b1;
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    cnt_d    = div_q - 16'd1;
                    tx_d     = 1'b0;
                    state_d  = S_START;
                end
            end
            S_START: if (tc) begin
                idx_d   = 3'd0;
                cnt_d   = div_q - 16'd1;
                tx_d    = shift_q[0];
                state_d = S_DATA;
            end
            S_DATA: if (tc) begin
                cnt_d = div_q - 16'd1;
                if (idx_q == 3'd7) begin
                    tx_d    = 1'b1;
                    state_d = S_STOP;
                end else begin
                    idx_d   = idx_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    tx_d    = shift_q[1];
                end
            end
            S_STOP: if (tc) begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    shift_d  = fifo_head;
                    cnt_d    = div_q - 16'd1;
                    tx_d     = 1'b0;
                    state_d  = S_START;
                end else begin
                    tx_d    = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            shift_q <= '0;
            idx_q   <= '0;
            cnt_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        rd_val = '0;
        case (sel)
            UART_STATUS:  rd_val = {{(XLEN-4){1'b0}}, ovf_q, busy, fifo_empty, fifo_full};
            UART_BAUDDIV: rd_val = {{(XLEN-16){1'b0}}, div_q};
            UART_CTRL:    rd_val = {{(XLEN-1){1'b0}}, irq_en_q};
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q    <= DEFAULT_DIV;
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            if (rd) rdata_q <= rd_val;
            if (push && fifo_full && !fifo_pop) ovf_q <= 1'b1;
            else if (wr && sel == UART_STATUS && wdata_i[STAT_OVF]) ovf_q <= 1'b0;
            if (wr && sel == UART_BAUDDIV) div_q <= div_sanitize(wdata_i[15:0]);
            if (wr && sel == UART_CTRL) irq_en_q <= wdata_i[0];
            irq_q <= irq_en_q & fifo_empty & ~busy;
        end
    end

    assign rdata_o = rdata_q;
    assign tx_o    = tx_q;
    assign irq_o   = irq_q;

endmodule

// File: tb/tb_uart_tx_dev.sv
// Directed self-checking bench for uart_tx_dev: register map, framing,
// back-to-back frames, overflow, interrupt and mid-frame reset.
module tb_uart_tx_dev;

    logic        clk_i, rst_i, req_i, we_i;
    logic [31:0] addr_i, wdata_i, rdata_o;
    logic        tx_o, irq_o;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_dev dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .req_i   (req_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_o (rdata_o),
        .tx_o    (tx_o),
        .irq_o   (irq_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        req_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        tick();
        req_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        req_i = 1'b1; we_i = 1'b0; addr_i = a;
        tick();
        req_i = 1'b0;
        d = rdata_o;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        repeat (3) tick();
        n_cmp++;
        if ({tx_o, irq_o, rdata_o} !== {1'b1, 1'b0, 32'h0}) begin
            n_err++;
            $display("FAIL reset_outputs got tx=%b irq=%b rdata=%h want tx=1 irq=0 rdata=0", tx_o, irq_o, rdata_o);
        end
        rst_i = 1'b0;
        tick();
        bus_read(32'h4, r);
        n_cmp++;
        if (r !== 32'h2) begin n_err++; $display("FAIL reset_status got %h want 00000002", r); end
        bus_read(32'h8, r);
        n_cmp++;
        if (r !== 32'd868) begin n_err++; $display("FAIL reset_bauddiv got %0d want 868", r); end
        bus_read(32'hC, r);
        n_cmp++;
        if (r !== 32'h0) begin n_err++; $display("FAIL reset_ctrl got %h want 0", r); end
        bus_read(32'h6, r);
        n_cmp++;
        if (r !== 32'h2) begin n_err++; $display("FAIL misaligned_status got %h want 00000002", r); end
    endtask

    task automatic test_single_frame();
        logic [31:0] r;
        logic [9:0]  frame;
        logic [3:0]  got;
        bus_write(32'h8, 32'hFFFF_0004);
        bus_read(32'h8, r);
        n_cmp++;
        if (r !== 32'h4) begin n_err++; $display("FAIL bauddiv_mask got %h want 00000004", r); end
        frame = {1'b1, 8'h55, 1'b0};
        bus_write(32'h0, 32'h55);
        for (int b = 0; b < 10; b++) begin
            for (int s = 0; s < 4; s++) begin
                tick();
                got[s] = tx_o;
            end
            n_cmp++;
            if (got !== {4{frame[b]}}) begin
                n_err++;
                $display("FAIL frame55_bit%0d got %b want %b", b, got, {4{frame[b]}});
            end
        end
        bus_read(32'h4, r);
        n_cmp++;
        if (r !== 32'h6) begin n_err++; $display("FAIL busy_at_N41_edge got %h want 00000006", r); end
        bus_read(32'h4, r);
        n_cmp++;
        if (r !== 32'h2) begin n_err++; $display("FAIL busy_cleared got %h want 00000002", r); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] r;
        logic        s [182];
        logic [19:0] got, exp;
        logic [9:0]  frame;
        bus_write(32'h8, 32'h2);
        for (int c = 0; c < 182; c++) begin
            if (c < 9) begin
                req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; wdata_i = c;
            end else begin
                req_i = 1'b0; we_i = 1'b0;
            end
            tick();
            s[c] = tx_o;
        end
        req_i = 1'b0; we_i = 1'b0;
        n_cmp++;
        if (s[0] !== 1'b1 || s[181] !== 1'b1) begin
            n_err++;
            $display("FAIL b2b_idle_edges got %b%b want 11", s[0], s[181]);
        end
        for (int k = 0; k < 9; k++) begin
            frame = {1'b1, k[7:0], 1'b0};
            for (int j = 0; j < 20; j++) begin
                got[j] = s[1 + 20*k + j];
                exp[j] = frame[j/2];
            end
            n_cmp++;
            if (got !== exp) begin
                n_err++;
                $display("FAIL b2b_frame%0d got %b want %b", k, got, exp);
            end
        end
        bus_read(32'h4, r);
        n_cmp++;
        if (r !== 32'h2) begin n_err++; $display("FAIL b2b_status got %h want 00000002", r); end
    endtask

    task automatic test_overflow();
        logic [31:0] r;
        bit          done;
        bus_write(32'h8, 32'd100);
        for (int i = 0; i < 10; i++) bus_write(32'h0, 32'hA0 + i);
        bus_read(32'h4, r);
        n_cmp++;
        if (r !== 32'hD) begin n_err++; $display("FAIL ovf_status got %h want 0000000d", r); end
        bus_write(32'h4, 32'h8);
        bus_read(32'h4, r);
        n_cmp++;
        if (r !== 32'h5) begin n_err++; $display("FAIL ovf_clear got %h want 00000005", r); end
        bus_write(32'h8, 32'h0);
        bus_read(32'h8, r);
        n_cmp++;
        if (r !== 32'h1) begin n_err++; $display("FAIL bauddiv_zero got %h want 00000001", r); end
        done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
            bus_read(32'h4, r);
            if (r == 32'h2) done = 1'b1;
        end
        n_cmp++;
        if (!done) begin n_err++; $display("FAIL ovf_drain got status %h want 00000002 within 3000 reads", r); end
    endtask

    task automatic test_irq();
        int bad;
        bus_write(32'h8, 32'd3);
        bus_write(32'hC, 32'h1);
        tick(); tick();
        n_cmp++;
        if (irq_o !== 1'b1) begin n_err++; $display("FAIL irq_idle got %b want 1", irq_o); end
        bus_write(32'h0, 32'h3C);
        bad = 0;
        for (int i = 0; i < 31; i++) begin
            tick();
            if (irq_o !== 1'b0) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL irq_busy got %0d cycles high want 0", bad); end
        tick();
        n_cmp++;
        if (irq_o !== 1'b1) begin n_err++; $display("FAIL irq_after_frame got %b want 1", irq_o); end
        bus_write(32'hC, 32'h0);
        n_cmp++;
        if (irq_o !== 1'b1) begin n_err++; $display("FAIL irq_disable_edge got %b want 1", irq_o); end
        tick();
        n_cmp++;
        if (irq_o !== 1'b0) begin n_err++; $display("FAIL irq_disabled got %b want 0", irq_o); end
    endtask

    task automatic test_reset_midframe();
        logic [31:0] r;
        int          bad;
        bus_write(32'h8, 32'd4);
        bus_write(32'h0, 32'h00);
        bus_write(32'h0, 32'h00);
        repeat (17) tick();
        n_cmp++;
        if (tx_o !== 1'b0) begin n_err++; $display("FAIL midframe_bit3 got %b want 0", tx_o); end
        rst_i = 1'b1;
        #1;
        n_cmp++;
        if (tx_o !== 1'b1) begin n_err++; $display("FAIL async_reset_tx got %b want 1", tx_o); end
        tick(); tick();
        rst_i = 1'b0;
        bus_read(32'h4, r);
        n_cmp++;
        if (r !== 32'h2) begin n_err++; $display("FAIL post_reset_status got %h want 00000002", r); end
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx_o !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL residual_frame got %0d low cycles want 0", bad); end
        bus_read(32'h8, r);
        n_cmp++;
        if (r !== 32'd868) begin n_err++; $display("FAIL post_reset_bauddiv got %0d want 868", r); end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_irq();
        test_reset_midframe();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
